fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/pc_reg.sv | 33 +++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths and FSM state encoding for the nibble fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int ADDR_W  = 8;
    localparam int NIB_W   = 4;
    localparam int INSTR_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_HI = 2'd1,
        FETCH_LO = 2'd2,
        VALID    = 2'd3
    } fetch_state_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with load, modulo-2^ADDR_W increment and
//               asynchronous reset to RESET_PC.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    // Load wins over increment so a jump never lands one past its target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_addr;
        end else if (inc) begin
            pc <= pc + 1'b1;
        end
    end

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Assembles 8-bit instructions from two successive nibbles of a
//               256x4 program ROM and hands them out with a valid/ready pair.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               halt,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [NIB_W-1:0]   rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic                w_pc_inc;
    logic                w_ld_hi;
    logic                w_ld_lo;
    logic [INSTR_W-1:0]  r_instr;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (jump),
        .load_addr (jump_addr),
        .inc       (w_pc_inc),
        .pc        (pc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A jump suppresses every other action, which also discards any half-built
    // or unaccepted instruction.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_inc    = 1'b0;
        w_ld_hi     = 1'b0;
        w_ld_lo     = 1'b0;
        if (jump) begin
            w_state_nxt = FETCH_HI;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_nxt = FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    w_ld_hi     = 1'b1;
                    w_pc_inc    = 1'b1;
                    w_state_nxt = FETCH_LO;
                end
                FETCH_LO: begin
                    w_ld_lo     = 1'b1;
                    w_pc_inc    = 1'b1;
                    w_state_nxt = VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        w_state_nxt = halt ? IDLE : FETCH_HI;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr <= '0;
        end else if (w_ld_hi) begin
            r_instr[INSTR_W-1:NIB_W] <= rom_data;
        end else if (w_ld_lo) begin
            r_instr[NIB_W-1:0] <= rom_data;
        end
    end

    assign rom_address = pc;
    assign instr       = r_instr;
    assign instr_valid = (r_state == VALID);
    assign busy        = (r_state != IDLE);

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       halt;
    logic       jump;
    logic [7:0] jump_addr;
    logic [7:0] rom_address;
    logic [3:0] rom_data;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc;
    logic       busy;

    logic [3:0] r_rom [256];
    int         checks;
    int         errors;

    fetch_unit #(
        .RESET_PC (8'h00)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .halt        (halt),
        .jump        (jump),
        .jump_addr   (jump_addr),
        .rom_address (rom_address),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .busy        (busy)
    );

    assign rom_data = r_rom[rom_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there as well.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        halt        = 1'b0;
        jump        = 1'b0;
        jump_addr   = 8'h00;
        instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) r_rom[i] = 4'h0;
        r_rom[8'h00] = 4'hA;
        r_rom[8'h01] = 4'h5;
        r_rom[8'h02] = 4'h3;
        r_rom[8'h03] = 4'hC;
        r_rom[8'h10] = 4'hF;
        r_rom[8'h11] = 4'h0;
        r_rom[8'hFE] = 4'h1;
        r_rom[8'hFF] = 4'h2;

        #3;
        check("rst_pc", pc, 8'h00);
        check("rst_instr", instr, 8'h00);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tick();
        check("idle_busy", busy, 1'b0);
        check("idle_addr", rom_address, 8'h00);

        // Basic fetch with ready held high.
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("f1_busy", busy, 1'b1);
        check("f1_valid_early", instr_valid, 1'b0);
        tick();
        check("f1_pc_mid", pc, 8'h01);
        tick();
        check("f1_valid", instr_valid, 1'b1);
        check("f1_instr", instr, 8'hA5);
        check("f1_pc", pc, 8'h02);
        tick();
        check("f2_drop_valid", instr_valid, 1'b0);
        tick();
        tick();
        check("f2_valid", instr_valid, 1'b1);
        check("f2_instr", instr, 8'h3C);
        check("f2_pc", pc, 8'h04);

        // Backpressure.
        apply_reset();
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", instr_valid, 1'b1);
            check("bp_instr", instr, 8'hA5);
            check("bp_pc", pc, 8'h02);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        check("bp_accept_valid", instr_valid, 1'b0);
        check("bp_accept_busy", busy, 1'b1);
        tick();
        tick();
        check("bp_next_instr", instr, 8'h3C);
        check("bp_next_pc", pc, 8'h04);

        // Halt held high from the start only takes effect at acceptance.
        apply_reset();
        halt = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("h_valid", instr_valid, 1'b1);
        check("h_instr", instr, 8'hA5);
        tick();
        check("h_busy", busy, 1'b0);
        check("h_pc", pc, 8'h02);
        check("h_valid_off", instr_valid, 1'b0);
        halt = 1'b0;
        tick();
        check("h_stay_idle", busy, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("h_restart_valid", instr_valid, 1'b1);
        check("h_restart_instr", instr, 8'h3C);
        check("h_restart_pc", pc, 8'h04);

        // PC wrap across 8'hFF, jump taken from VALID with ready high.
        r_rom[8'h00] = 4'h7;
        r_rom[8'h01] = 4'h9;
        jump = 1'b1;
        jump_addr = 8'hFE;
        tick();
        jump = 1'b0;
        check("w_pc_load", pc, 8'hFE);
        check("w_valid_off", instr_valid, 1'b0);
        tick();
        tick();
        check("w1_instr", instr, 8'h12);
        check("w1_pc", pc, 8'h00);
        tick();
        tick();
        tick();
        check("w2_instr", instr, 8'h79);
        check("w2_pc", pc, 8'h02);
        r_rom[8'h00] = 4'hA;
        r_rom[8'h01] = 4'h5;

        // Jump in FETCH_LO drops the partial instruction.
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        jump = 1'b1;
        jump_addr = 8'h10;
        tick();
        jump = 1'b0;
        check("j_valid_off", instr_valid, 1'b0);
        check("j_pc", pc, 8'h10);
        tick();
        tick();
        check("j_valid", instr_valid, 1'b1);
        check("j_instr", instr, 8'hF0);
        check("j_pc_after", pc, 8'h12);

        // Jump beats instr_ready=0 and discards the unaccepted instruction.
        instr_ready = 1'b0;
        tick();
        check("j_hold_instr", instr, 8'hF0);
        jump = 1'b1;
        jump_addr = 8'h02;
        tick();
        jump = 1'b0;
        check("jv_valid_off", instr_valid, 1'b0);
        check("jv_pc", pc, 8'h02);
        tick();
        tick();
        check("jv_instr", instr, 8'h3C);
        check("jv_pc_after", pc, 8'h04);

        // Asynchronous reset while in FETCH_HI.
        jump = 1'b1;
        jump_addr = 8'h00;
        tick();
        jump = 1'b0;
        check("r_pre_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("r_pc", pc, 8'h00);
        check("r_instr", instr, 8'h00);
        check("r_valid", instr_valid, 1'b0);
        check("r_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("r_no_valid", instr_valid, 1'b0);
            check("r_idle", busy, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
